// File: rtl/nn_mem_pkg.sv
// -----------------------------------------------------------------------------
// nn_mem_pkg
// Shared types and helpers for the neural-network weight memory controllers.
//   state_e   : burst controller FSM states
//   gnt_e     : which requester holds (or has priority for) the shared port
//   RD_IDX /
//   WR_IDX    : bit positions of the read and write requesters in req/gnt vectors
//   satLen()  : clamps a requested burst length to the memory depth
// -----------------------------------------------------------------------------
package nn_mem_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  typedef enum logic {
    GNT_RD = 1'b0,
    GNT_WR = 1'b1
  } gnt_e;

  localparam int unsigned RD_IDX = 0;
  localparam int unsigned WR_IDX = 1;

  // A burst can never usefully be longer than the memory itself, so any
  // larger request is clamped to one full pass over the array.
  function automatic int unsigned satLen(input int unsigned len,
                                         input int unsigned size);
    return (len > size) ? size : len;
  endfunction

endpackage

// File: rtl/weight_mem_ctrl_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-requester round-robin arbiter with a registered priority pointer.
//   clk_i     : clock, rising edge
//   rst_ni    : asynchronous active-low reset (pointer returns to the reader)
//   req_i     : request vector, bit RD_IDX = reader, bit WR_IDX = writer
//   advance_i : when high, a grant made this cycle moves the pointer
//   gnt_o     : one-hot grant (or zero when nobody requests), combinational
// -----------------------------------------------------------------------------
module rr_arb2
  import nn_mem_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] gnt_o
);

  gnt_e prio_q;

  // A lone requester always wins; the pointer only matters on a tie.
  always_comb begin
    gnt_o = 2'b00;
    if (req_i[RD_IDX] && req_i[WR_IDX]) begin
      gnt_o = (prio_q == GNT_RD) ? 2'b01 : 2'b10;
    end else begin
      gnt_o = req_i;
    end
  end

  // After any grant the pointer favours the requester that did not win, which
  // makes continuous contention alternate strictly.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q <= GNT_RD;
    end else if (advance_i && (gnt_o != 2'b00)) begin
      prio_q <= gnt_o[RD_IDX] ? GNT_WR : GNT_RD;
    end
  end

endmodule

// File: rtl/weight_mem_ctrl.sv
// -----------------------------------------------------------------------------
// weight_mem_ctrl
// Shares the single port of the weight memory between host writes and layer
// read bursts. The memory itself lives in the parent; this block drives its
// address, write-data and write-enable pins and registers the read data.
//   clk_i, rst_ni        : clock (rising edge), async active-low reset
//   wr_valid_i/addr/data : host write request; wr_ready_o accepts it (comb)
//   rd_start_i/base/len  : burst request (length saturates at SIZE)
//   rd_busy_o            : burst in progress
//   rd_data_o/valid_o    : registered burst data stream
//   rd_done_o            : one-cycle pulse with the final beat (or alone for len 0)
//   mem_addr/wdata/wr_en : memory pins (comb); mem_rdata_i is comb read data
// -----------------------------------------------------------------------------
module weight_mem_ctrl
  import nn_mem_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned SIZE  = 64,
  localparam int unsigned AW    = $clog2(SIZE)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_valid_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic             wr_ready_o,
  input  logic             rd_start_i,
  input  logic [AW-1:0]    rd_base_i,
  input  logic [AW:0]      rd_len_i,
  output logic             rd_busy_o,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             rd_valid_o,
  output logic             rd_done_o,
  output logic [AW-1:0]    mem_addr_o,
  output logic [WIDTH-1:0] mem_wdata_o,
  output logic             mem_wr_en_o,
  input  logic [WIDTH-1:0] mem_rdata_i
);

  state_e           state_q;
  logic             ready_q;
  logic [AW-1:0]    addr_q;
  logic [AW-1:0]    addr_d;
  logic [AW:0]      remain_q;
  logic [AW:0]      len_d;
  logic [WIDTH-1:0] rdData_q;
  logic             rdValid_q;
  logic             rdDone_q;
  logic             inBurst;
  logic             readBeat;
  logic [1:0]       req;
  logic [1:0]       gnt;

  assign inBurst = (state_q == BURST);

  // The reader only competes for the port while a burst is running; in IDLE
  // the host owns the port outright.
  assign req = {wr_valid_i, inBurst};

  rr_arb2 u_arb (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (req),
    .advance_i (inBurst),
    .gnt_o     (gnt)
  );

  assign readBeat = inBurst && gnt[RD_IDX];

  // ready_q holds every host-visible output quiet until the first clock edge
  // after reset release has passed.
  assign wr_ready_o  = ready_q && (inBurst ? gnt[WR_IDX] : 1'b1);
  assign mem_wr_en_o = wr_valid_i && wr_ready_o;
  assign mem_addr_o  = !ready_q ? '0 : (readBeat ? addr_q : wr_addr_i);
  assign mem_wdata_o = ready_q ? wr_data_i : '0;

  // Explicit wrap so the burst address stays legal for non-power-of-two SIZE.
  assign addr_d = (addr_q == AW'(SIZE - 1)) ? '0 : addr_q + AW'(1);
  assign len_d  = (AW+1)'(satLen(32'(rd_len_i), SIZE));

  assign rd_busy_o  = inBurst;
  assign rd_data_o  = rdData_q;
  assign rd_valid_o = rdValid_q;
  assign rd_done_o  = rdDone_q;

  // Burst sequencer. A zero-length request never enters BURST and only
  // produces the done pulse; the final read beat returns straight to IDLE so a
  // new start is accepted in the same cycle its data appears.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      ready_q   <= 1'b0;
      addr_q    <= '0;
      remain_q  <= '0;
      rdData_q  <= '0;
      rdValid_q <= 1'b0;
      rdDone_q  <= 1'b0;
    end else begin
      ready_q   <= 1'b1;
      rdValid_q <= 1'b0;
      rdDone_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ready_q && rd_start_i) begin
            addr_q   <= rd_base_i;
            remain_q <= len_d;
            if (len_d == '0) begin
              rdDone_q <= 1'b1;
            end else begin
              state_q <= BURST;
            end
          end
        end
        BURST: begin
          if (readBeat) begin
            rdData_q  <= mem_rdata_i;
            rdValid_q <= 1'b1;
            addr_q    <= addr_d;
            remain_q  <= remain_q - (AW+1)'(1);
            if (remain_q == (AW+1)'(1)) begin
              state_q  <= IDLE;
              rdDone_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_weight_mem_ctrl
// Self-checking bench for weight_mem_ctrl with a behavioural memory attached
// to its pins and a transaction-level reference model of the controller.
// -----------------------------------------------------------------------------
module tb_weight_mem_ctrl;

  localparam int WIDTH = 8;
  localparam int SIZE  = 64;
  localparam int AW    = 6;

  logic             clk;
  logic             rstN;
  logic             wrValid;
  logic [AW-1:0]    wrAddr;
  logic [WIDTH-1:0] wrData;
  logic             wrReady;
  logic             rdStart;
  logic [AW-1:0]    rdBase;
  logic [AW:0]      rdLen;
  logic             rdBusy;
  logic [WIDTH-1:0] rdData;
  logic             rdValid;
  logic             rdDone;
  logic [AW-1:0]    memAddr;
  logic [WIDTH-1:0] memWdata;
  logic             memWrEn;
  logic [WIDTH-1:0] memRdata;

  logic [WIDTH-1:0] benchMem [SIZE];

  int checks;
  int errors;

  // Reference model state: what the controller should be doing, expressed as
  // "is a burst running, where is it, how many words are left, whose turn".
  bit             mInit;
  bit             mBusy;
  bit             mWrTurn;
  int             mNext;
  int             mLeft;
  logic [7:0]     mRdData;
  bit             mRdValid;
  bit             mRdDone;
  logic [7:0]     modelMem [SIZE];

  typedef struct {
    bit rs;
    bit wv;
    int wa;
    int wd;
    bit eBusy;
    bit eReady;
    bit eValid;
    bit eDone;
    int eData;
  } vec_t;

  vec_t vecs[10];

  weight_mem_ctrl #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
    .clk_i       (clk),
    .rst_ni      (rstN),
    .wr_valid_i  (wrValid),
    .wr_addr_i   (wrAddr),
    .wr_data_i   (wrData),
    .wr_ready_o  (wrReady),
    .rd_start_i  (rdStart),
    .rd_base_i   (rdBase),
    .rd_len_i    (rdLen),
    .rd_busy_o   (rdBusy),
    .rd_data_o   (rdData),
    .rd_valid_o  (rdValid),
    .rd_done_o   (rdDone),
    .mem_addr_o  (memAddr),
    .mem_wdata_o (memWdata),
    .mem_wr_en_o (memWrEn),
    .mem_rdata_i (memRdata)
  );

  // Single-port weight memory: combinational read, synchronous write.
  assign memRdata = benchMem[memAddr];

  always @(posedge clk) begin
    if (memWrEn) benchMem[memAddr] <= memWdata;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    mInit    = 1'b0;
    mBusy    = 1'b0;
    mWrTurn  = 1'b0;
    mNext    = 0;
    mLeft    = 0;
    mRdData  = '0;
    mRdValid = 1'b0;
    mRdDone  = 1'b0;
  endtask

  // Drives one cycle of inputs (called at a falling edge), compares every
  // output with the model, advances the model and waits for the next falling edge.
  task automatic applyStimulus(input bit wv, input int wa, input int wd,
                               input bit rs, input int rb, input int rl);
    bit writeWins;
    bit readBeat;
    bit expReady;
    bit expWrEn;
    int len;
    wrValid = wv;
    wrAddr  = AW'(wa);
    wrData  = WIDTH'(wd);
    rdStart = rs;
    rdBase  = AW'(rb);
    rdLen   = (AW+1)'(rl);
    #1;
    writeWins = mBusy && wv && mWrTurn;
    readBeat  = mBusy && !writeWins;
    expReady  = mInit && (!mBusy || writeWins);
    expWrEn   = wv && expReady;
    checkOutput("wr_ready", wrReady, expReady);
    checkOutput("mem_wr_en", memWrEn, expWrEn);
    checkOutput("rd_busy", rdBusy, mBusy);
    checkOutput("rd_valid", rdValid, mRdValid);
    checkOutput("rd_done", rdDone, mRdDone);
    checkOutput("rd_data", rdData, mRdData);
    if (!mInit) begin
      checkOutput("mem_addr_rst", memAddr, 0);
      checkOutput("mem_wdata_rst", memWdata, 0);
    end else if (expWrEn) begin
      checkOutput("mem_addr_wr", memAddr, wa % SIZE);
      checkOutput("mem_wdata", memWdata, wd % 256);
    end else if (readBeat) begin
      checkOutput("mem_addr_rd", memAddr, mNext);
    end
    if (rstN) begin
      mRdValid = 1'b0;
      mRdDone  = 1'b0;
      if (readBeat) begin
        mRdData  = modelMem[mNext];
        mRdValid = 1'b1;
        mNext    = (mNext + 1) % SIZE;
        mLeft    = mLeft - 1;
        mWrTurn  = 1'b1;
        if (mLeft == 0) begin
          mBusy   = 1'b0;
          mRdDone = 1'b1;
        end
      end else if (mBusy) begin
        mWrTurn = 1'b0;
      end else if (mInit && rs) begin
        len = (rl > SIZE) ? SIZE : rl;
        if (len == 0) begin
          mRdDone = 1'b1;
        end else begin
          mBusy = 1'b1;
          mNext = rb % SIZE;
          mLeft = len;
        end
      end
      if (expWrEn) modelMem[wa % SIZE] = WIDTH'(wd);
      mInit = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 0, 0, 1'b0, 0, 0);
  endtask

  initial begin
    int wrapSeq[8];
    int beats;
    int busyCycles;
    bit wrote;
    bit accepted;
    bit doneSeen;

    checks = 0;
    errors = 0;
    modelReset();
    wrValid = 1'b0; wrAddr = '0; wrData = '0;
    rdStart = 1'b0; rdBase = '0; rdLen = '0;
    rstN = 1'b0;

    // Contended 4-word burst from base 10 with the host writing every cycle.
    vecs[0] = '{1'b1, 1'b1, 40, 'hC0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    vecs[1] = '{1'b0, 1'b1, 41, 'hC1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    vecs[2] = '{1'b0, 1'b1, 42, 'hC2, 1'b1, 1'b1, 1'b1, 1'b0, 10};
    vecs[3] = '{1'b0, 1'b1, 43, 'hC3, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    vecs[4] = '{1'b0, 1'b1, 44, 'hC4, 1'b1, 1'b1, 1'b1, 1'b0, 11};
    vecs[5] = '{1'b0, 1'b1, 45, 'hC5, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    vecs[6] = '{1'b0, 1'b1, 46, 'hC6, 1'b1, 1'b1, 1'b1, 1'b0, 12};
    vecs[7] = '{1'b0, 1'b1, 47, 'hC7, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    vecs[8] = '{1'b0, 1'b1, 48, 'hC8, 1'b0, 1'b1, 1'b1, 1'b1, 13};
    vecs[9] = '{1'b0, 1'b0, 49, 'hC9, 1'b0, 1'b1, 1'b0, 1'b0, 0};

    wrapSeq = '{60, 61, 62, 63, 0, 1, 2, 3};

    @(negedge clk);

    // Held in reset with live requests: everything must stay quiet.
    applyStimulus(1'b1, 5, 'h77, 1'b1, 0, 4);
    applyStimulus(1'b1, 5, 'h77, 1'b1, 0, 4);
    rstN = 1'b1;
    applyStimulus(1'b1, 5, 'h77, 1'b1, 0, 4);
    checkOutput("idle_after_release_busy", rdBusy, 0);

    // Preload address i with value i.
    for (int i = 0; i < SIZE; i++) applyStimulus(1'b1, i, i, 1'b0, 0, 0);

    $display("[TB] contended burst table");
    busyCycles = 0;
    for (int r = 0; r < 10; r++) begin
      wrValid = vecs[r].wv;
      wrAddr  = AW'(vecs[r].wa);
      wrData  = WIDTH'(vecs[r].wd);
      rdStart = vecs[r].rs;
      rdBase  = AW'(10);
      rdLen   = (AW+1)'(4);
      #1;
      checkOutput($sformatf("tbl%0d_busy", r), rdBusy, vecs[r].eBusy);
      checkOutput($sformatf("tbl%0d_ready", r), wrReady, vecs[r].eReady);
      checkOutput($sformatf("tbl%0d_wren", r), memWrEn, vecs[r].eReady && vecs[r].wv);
      checkOutput($sformatf("tbl%0d_valid", r), rdValid, vecs[r].eValid);
      checkOutput($sformatf("tbl%0d_done", r), rdDone, vecs[r].eDone);
      if (vecs[r].eValid) checkOutput($sformatf("tbl%0d_data", r), rdData, vecs[r].eData);
      if (rdBusy) busyCycles++;
      applyStimulus(vecs[r].wv, vecs[r].wa, vecs[r].wd, vecs[r].rs, 10, 4);
    end
    checkOutput("tbl_busy_cycles", busyCycles, 7);

    $display("[TB] wrapping burst");
    applyStimulus(1'b0, 0, 0, 1'b1, 60, 8);
    for (int j = 1; j <= 9; j++) begin
      checkOutput($sformatf("wrap%0d_valid", j), rdValid, j >= 2);
      checkOutput($sformatf("wrap%0d_done", j), rdDone, j == 9);
      if (j >= 2) checkOutput($sformatf("wrap%0d_data", j), rdData, wrapSeq[j-2]);
      idleCycle();
    end

    $display("[TB] write then single-word burst");
    wrValid = 1'b1; wrAddr = AW'(3); wrData = 8'hA5; rdStart = 1'b0;
    #1;
    checkOutput("a5_wr_ready", wrReady, 1);
    applyStimulus(1'b1, 3, 'hA5, 1'b0, 0, 0);
    applyStimulus(1'b0, 0, 0, 1'b1, 3, 1);
    idleCycle();
    checkOutput("a5_valid", rdValid, 1);
    checkOutput("a5_done", rdDone, 1);
    checkOutput("a5_data", rdData, 'hA5);
    idleCycle();

    $display("[TB] write inside burst");
    applyStimulus(1'b0, 0, 0, 1'b1, 20, 4);
    beats = 0;
    wrote = 1'b0;
    for (int k = 0; k < 15 && beats < 4; k++) begin
      wrValid = !wrote; wrAddr = AW'(22); wrData = 8'h5C; rdStart = 1'b0;
      #1;
      accepted = wrReady && !wrote;
      if (rdValid) begin
        beats++;
        if (beats == 3) checkOutput("mid_write_beat3", rdData, 'h5C);
      end
      applyStimulus(!wrote, 22, 'h5C, 1'b0, 0, 0);
      if (accepted) wrote = 1'b1;
    end
    checkOutput("mid_write_beats", beats, 4);
    idleCycle();

    $display("[TB] zero and oversized length");
    applyStimulus(1'b0, 0, 0, 1'b1, 5, 0);
    checkOutput("len0_done", rdDone, 1);
    checkOutput("len0_valid", rdValid, 0);
    checkOutput("len0_busy", rdBusy, 0);
    idleCycle();
    applyStimulus(1'b0, 0, 0, 1'b1, 7, 100);
    beats = 0;
    doneSeen = 1'b0;
    for (int k = 0; k < 80; k++) begin
      if (rdValid) beats++;
      if (rdDone) begin
        doneSeen = 1'b1;
        break;
      end
      idleCycle();
    end
    checkOutput("len100_done_seen", doneSeen, 1);
    checkOutput("len100_beats", beats, 64);
    idleCycle();

    $display("[TB] reset during burst");
    applyStimulus(1'b0, 0, 0, 1'b1, 0, 8);
    beats = 0;
    for (int k = 0; k < 6; k++) begin
      if (rdValid) beats++;
      if (beats == 2) break;
      idleCycle();
    end
    checkOutput("rst_mid_beats_before", beats, 2);
    rstN = 1'b0;
    #1;
    checkOutput("rst_mid_busy", rdBusy, 0);
    checkOutput("rst_mid_valid", rdValid, 0);
    checkOutput("rst_mid_done", rdDone, 0);
    checkOutput("rst_mid_ready", wrReady, 0);
    modelReset();
    idleCycle();
    rstN = 1'b1;
    idleCycle();
    for (int k = 0; k < 6; k++) begin
      checkOutput("post_rst_ready", wrReady, 1);
      checkOutput("post_rst_valid", rdValid, 0);
      idleCycle();
    end

    $display("[TB] randomized traffic");
    for (int k = 0; k < 600; k++) begin
      int rl;
      rl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 100)) : int'($urandom_range(0, 9));
      applyStimulus($urandom_range(0, 1) == 1, int'($urandom_range(0, SIZE - 1)),
                    int'($urandom_range(0, 255)), $urandom_range(0, 7) == 0,
                    int'($urandom_range(0, SIZE - 1)), rl);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
